phy_link_ctrl: RTL
==================

// Module: phy_link_ctrl
// PURPOSE
//  Link-training sequencer that sits in front of the 4-lane phy (tx lanes in0..in3/validin,
//  rx lanes out0..out3/validout). After reset it drives COM (8'hBC) on all lanes until the rx side
//  returns COM on all 4 lanes for LOCK_CNT consecutive cycles. It then sends IDLE (8'h7C) for
//  IDL_CNT cycles and enters ACTIVE, where user bytes pass to the phy. Rx lane loss forces retraining.
// PARAMETERS
//  LOCK_CNT   8    consecutive all-lane COM cycles required for lock (1..255)
//  IDL_CNT    4    IDLE symbols sent before ACTIVE (1..255)
//  TIMEOUT    64   max cycles in TRAIN per attempt before a retry (2..65535)
//  MAX_RETRY  3    failed attempts before FAIL (1..15)
//  LOSS_CNT   4    consecutive rx_valid!=4'hF cycles in ACTIVE that drop the link (1..255)
// PORTS
//  clk1f      in   1    single clock; all logic on posedge
//  reset      in   1    asynchronous, active-high reset
//  enable     in   1    1 = run training; 0 = return to IDLE
//  usr_data0..3 in 8    user byte per lane
//  usr_valid  in   4    per-lane user valid
//  usr_ready  out  1    1 only in ACTIVE; user bytes accepted when usr_ready=1
//  tx_data0..3 out 8    to phy in0..in3
//  tx_valid   out  4    to phy validin
//  rx_data0..3 in  8    from phy out0..out3
//  rx_valid   in   4    from phy validout
//  link_up    out  1    1 while in ACTIVE
//  link_fail  out  1    1 while in FAIL
//  state_o    out  3    current state encoding, for debug
//  retry_o    out  4    attempts failed since last IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset values: tx_data*=0, tx_valid=0, usr_ready=0, link_up=0,
//    link_fail=0, state_o=IDLE, retry_o=0, and all internal counters=0.
//  - States:
//    IDLE=0: tx_valid=0, tx_data=0. Goes to TRAIN when enable=1.
//    TRAIN=1: tx_data*=8'hBC, tx_valid=4'hF.
//      * lock_cnt increments when rx_valid==4'hF and all rx_data==8'hBC; otherwise it clears to 0.
//      * When lock_cnt reaches LOCK_CNT, go to SEND_IDL.
//      * tmo_cnt increments every cycle. At TIMEOUT without lock: retry+1, both counters clear, and
//        the block stays in TRAIN. When retry reaches MAX_RETRY it goes to FAIL instead.
//      * Lock and timeout in the same cycle: lock wins.
//    SEND_IDL=2: tx_data*=8'h7C, tx_valid=4'hF for exactly IDL_CNT cycles, then ACTIVE.
//    ACTIVE=3: usr_ready=1, link_up=1. tx_data*<=usr_data*, tx_valid<=usr_valid (1-cycle latency).
//      * loss_cnt increments when rx_valid!=4'hF and clears when rx_valid==4'hF.
//      * When loss_cnt reaches LOSS_CNT, go to TRAIN: link_up=0, retry cleared, counters cleared.
//    FAIL=4: tx_valid=0, link_fail=1. Sticky until enable=0 or reset.
//  - enable=0 in any state moves to IDLE on the next edge and clears retry and all counters.
//    This has priority over every other transition.
//  - usr_ready falls in the same cycle link_up falls. A user byte presented on the last ACTIVE
//    cycle is still forwarded. No user byte is forwarded from any other state.
//  - Counters saturate and never wrap. Counter widths come from the parameter maxima above.
//  - Asynchronous reset mid-training returns immediately to the reset values above.
// STRUCTURE
//  - Shared package/include: symbol constants COM=8'hBC, IDL=8'h7C, and the 3-bit state encodings.
//  - One sub-module: phy_lane_match. It is combinational and produces all_com=(rx_valid==4'hF)
//    and every rx_data==COM. It is reused by the rx word-alignment logic.
//  - The FSM, counters and output registers live in the top module.
// TESTING
//  - Bench wraps the phy in a loopback so that rx follows tx after a fixed delay.
//  - Normal bring-up, LOCK_CNT=8, IDL_CNT=4, enable=1: 8 cycles of all-lane 8'hBC on rx -> SEND_IDL,
//    4 cycles of 8'h7C, then link_up=1, usr_ready=1. Check 4'hF on tx_valid throughout.
//  - Lock broken: rx lane2=8'h00 on the 5th match cycle -> lock_cnt=0. Lock then needs 8 fresh cycles.
//  - Timeout and fail, TIMEOUT=64, MAX_RETRY=3, rx_valid=0: retry_o steps 1,2 at cycles 64 and 128.
//    At cycle 192 the block is in FAIL with link_fail=1, tx_valid=0. Then enable=0 -> IDLE, retry_o=0.
//  - Data path in ACTIVE: usr_data0..3=8'h11,22,33,44 with usr_valid=4'hF -> same bytes on tx the
//    next cycle. usr_valid=4'b0101 -> tx_valid=4'b0101.
//  - Lane loss, LOSS_CNT=4: rx_valid=4'h7 for 3 cycles then 4'hF -> stays ACTIVE. 4'h7 for 4 cycles
//    -> TRAIN with link_up=0 and tx 8'hBC on the next cycle.
//  - Reset and enable: reset pulse mid-SEND_IDL -> all outputs 0 asynchronously.
//    enable=0 in the same cycle lock completes -> IDLE, not SEND_IDL.

Source files
------------

// File: rtl/phy_link_ctrl_pkg.sv
// Shared line symbols, state encodings and saturating counter helpers for the phy link controller.
package phy_link_ctrl_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TRAIN    = 3'd1;
    localparam logic [2:0] ST_SEND_IDL = 3'd2;
    localparam logic [2:0] ST_ACTIVE   = 3'd3;
    localparam logic [2:0] ST_FAIL     = 3'd4;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/phy_link_ctrl_lane_match.sv
// Combinational detector: all four rx lanes valid and carrying the COM symbol.
module phy_lane_match (
    input  logic [3:0] rx_valid,
    input  logic [7:0] rx_data0,
    input  logic [7:0] rx_data1,
    input  logic [7:0] rx_data2,
    input  logic [7:0] rx_data3,
    output logic       all_com
);
    import phy_link_ctrl_pkg::*;

    assign all_com = (rx_valid == 4'hF) && (rx_data0 == COM) && (rx_data1 == COM)
                     && (rx_data2 == COM) && (rx_data3 == COM);

endmodule

// File: rtl/phy_link_ctrl.sv
// Link-training sequencer in front of a 4-lane phy: COM training, IDLE preamble, then user traffic.
module phy_link_ctrl #(
    parameter int LOCK_CNT  = 8,
    parameter int IDL_CNT   = 4,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3,
    parameter int LOSS_CNT  = 4
) (
    input  logic       clk1f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] usr_data0,
    input  logic [7:0] usr_data1,
    input  logic [7:0] usr_data2,
    input  logic [7:0] usr_data3,
    input  logic [3:0] usr_valid,
    output logic       usr_ready,
    output logic [7:0] tx_data0,
    output logic [7:0] tx_data1,
    output logic [7:0] tx_data2,
    output logic [7:0] tx_data3,
    output logic [3:0] tx_valid,
    input  logic [7:0] rx_data0,
    input  logic [7:0] rx_data1,
    input  logic [7:0] rx_data2,
    input  logic [7:0] rx_data3,
    input  logic [3:0] rx_valid,
    output logic       link_up,
    output logic       link_fail,
    output logic [2:0] state_o,
    output logic [3:0] retry_o
);
    import phy_link_ctrl_pkg::*;

    localparam logic [7:0]  LOCK_TGT  = 8'(LOCK_CNT);
    localparam logic [7:0]  IDL_TGT   = 8'(IDL_CNT);
    localparam logic [15:0] TMO_TGT   = 16'(TIMEOUT);
    localparam logic [3:0]  RETRY_TGT = 4'(MAX_RETRY);
    localparam logic [7:0]  LOSS_TGT  = 8'(LOSS_CNT);

    logic            all_com;
    logic [2:0]      state_q, state_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d, lock_inc;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic [3:0]      retry_q, retry_d, retry_inc;
    logic [7:0]      idl_cnt_q, idl_cnt_d, idl_inc;
    logic [7:0]      loss_cnt_q, loss_cnt_d, loss_inc;
    logic [3:0][7:0] tx_data_q, tx_data_d;
    logic [3:0]      tx_valid_q, tx_valid_d;
    logic            usr_ready_q, usr_ready_d;
    logic            link_up_q, link_up_d;
    logic            link_fail_q, link_fail_d;

    phy_lane_match u_lane_match (
        .rx_valid (rx_valid),
        .rx_data0 (rx_data0),
        .rx_data1 (rx_data1),
        .rx_data2 (rx_data2),
        .rx_data3 (rx_data3),
        .all_com  (all_com)
    );

    assign lock_inc  = all_com ? sat_inc8(lock_cnt_q) : 8'd0;
    assign tmo_inc   = sat_inc16(tmo_cnt_q);
    assign retry_inc = sat_inc4(retry_q);
    assign idl_inc   = sat_inc8(idl_cnt_q);
    assign loss_inc  = (rx_valid != 4'hF) ? sat_inc8(loss_cnt_q) : 8'd0;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        retry_d    = retry_q;
        idl_cnt_d  = idl_cnt_q;
        loss_cnt_d = loss_cnt_q;
        if (!enable) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
            tmo_cnt_d  = '0;
            retry_d    = '0;
            idl_cnt_d  = '0;
            loss_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_TRAIN;
                ST_TRAIN: begin
                    lock_cnt_d = lock_inc;
                    tmo_cnt_d  = tmo_inc;
                    // A lock completing on the timeout cycle takes precedence over the retry.
                    if (lock_inc == LOCK_TGT) begin
                        state_d    = ST_SEND_IDL;
                        lock_cnt_d = '0;
                        tmo_cnt_d  = '0;
                    end else if (tmo_inc == TMO_TGT) begin
                        lock_cnt_d = '0;
                        tmo_cnt_d  = '0;
                        retry_d    = retry_inc;
                        if (retry_inc == RETRY_TGT) begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_SEND_IDL: begin
                    idl_cnt_d = idl_inc;
                    if (idl_inc == IDL_TGT) begin
                        state_d   = ST_ACTIVE;
                        idl_cnt_d = '0;
                    end
                end
                ST_ACTIVE: begin
                    loss_cnt_d = loss_inc;
                    if (loss_inc == LOSS_TGT) begin
                        state_d    = ST_TRAIN;
                        loss_cnt_d = '0;
                        retry_d    = '0;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status flags track the next state; the lane byte accepted on the final ACTIVE cycle still goes out.
    always_comb begin
        usr_ready_d = (state_d == ST_ACTIVE);
        link_up_d   = (state_d == ST_ACTIVE);
        link_fail_d = (state_d == ST_FAIL);
        tx_data_d   = '0;
        tx_valid_d  = '0;
        if (state_q == ST_ACTIVE) begin
            tx_data_d  = {usr_data3, usr_data2, usr_data1, usr_data0};
            tx_valid_d = usr_valid;
        end else if (state_d == ST_TRAIN) begin
            tx_data_d  = {4{COM}};
            tx_valid_d = 4'hF;
        end else if (state_d == ST_SEND_IDL) begin
            tx_data_d  = {4{IDL}};
            tx_valid_d = 4'hF;
        end
    end

    always_ff @(posedge clk1f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            idl_cnt_q   <= '0;
            loss_cnt_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= '0;
            usr_ready_q <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            idl_cnt_q   <= idl_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            usr_ready_q <= usr_ready_d;
            link_up_q   <= link_up_d;
            link_fail_q <= link_fail_d;
        end
    end

    assign tx_data0  = tx_data_q[0];
    assign tx_data1  = tx_data_q[1];
    assign tx_data2  = tx_data_q[2];
    assign tx_data3  = tx_data_q[3];
    assign tx_valid  = tx_valid_q;
    assign usr_ready = usr_ready_q;
    assign link_up   = link_up_q;
    assign link_fail = link_fail_q;
    assign state_o   = state_q;
    assign retry_o   = retry_q;

endmodule
